sequenciador_decod: RTL and testbench

Session controller and two-requester arbiter for the 7-bit symbol decoder FSM (4-bit state output `Saida`; 8 = error, 9 and 10 = terminal accept). The controller has three jobs:
- Grant the single decoder to one of two symbol sources, round-robin.
- Clear the decoder at session start, feed it one symbol per `Controle` strobe and watch its state.
- Close the session on accept, error, symbol-count overflow, requester withdrawal or timeout, and report the final code.

---
 rtl/sequenciador_decod.sv | 215 +++++++++++++++++++++
 tb/tb_sequenciador_decod.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequenciador_decod.sv
// Session controller and round-robin arbiter feeding one 7-bit symbol decoder from two sources.
// Define SEQ_DECOD_TIMEOUT_EN to abort a session after TIMEOUT idle cycles in RECV.
module sequenciador_decod #(
    parameter int unsigned MAX_SIMB = 8,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       ReqA,
    input  logic       ReqB,
    input  logic       ValidA,
    input  logic       ValidB,
    input  logic [6:0] SimboloA,
    input  logic [6:0] SimboloB,
    output logic       ReadyA,
    output logic       ReadyB,
    output logic       GntA,
    output logic       GntB,
    output logic [6:0] Dec_Entrada,
    output logic       Dec_Controle,
    output logic       Dec_Reset,
    input  logic [3:0] Dec_Saida,
    output logic       Fim,
    output logic [3:0] Codigo,
    output logic       Erro,
    output logic       Ocupado
);

    localparam int unsigned SYM_W = 7;
    localparam int unsigned OUT_W = 4;
    localparam int unsigned CNT_W = $clog2(MAX_SIMB + 1);

    localparam logic [OUT_W-1:0] SAIDA_ERRO  = OUT_W'(8);
    localparam logic [OUT_W-1:0] SAIDA_ACC_0 = OUT_W'(9);
    localparam logic [OUT_W-1:0] SAIDA_ACC_1 = OUT_W'(10);
    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(MAX_SIMB);

    if (MAX_SIMB == 0 || TIMEOUT == 0) begin : g_bad_params
        $error("sequenciador_decod: MAX_SIMB and TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        LIMPA,
        RECV,
        EMITE,
        CHECA,
        FIM
    } state_t;

    state_t           state, state_n;
    logic             sel, sel_n;       // granted source: 0 = A, 1 = B
    logic             ptr, ptr_n;       // source favoured when both request
    logic [CNT_W-1:0] cnt, cnt_n;

    logic             gnt_a_n, gnt_b_n, ready_a_n, ready_b_n;
    logic [SYM_W-1:0] dec_entrada_n;
    logic             dec_controle_n, dec_reset_n, fim_n, erro_n, ocupado_n;
    logic [OUT_W-1:0] codigo_n;

    logic             pick_b, sel_req, sel_valid, sel_ready, xfer;
    logic [SYM_W-1:0] sel_sym;
    logic             close, close_err;

`ifdef SEQ_DECOD_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    logic [WAIT_W-1:0] wait_cnt, wait_n;
`endif

    assign pick_b    = ReqB & (~ReqA | ptr);
    assign sel_req   = sel ? ReqB     : ReqA;
    assign sel_valid = sel ? ValidB   : ValidA;
    assign sel_ready = sel ? ReadyB   : ReadyA;
    assign sel_sym   = sel ? SimboloB : SimboloA;
    assign xfer      = sel_valid & sel_ready;

    // Next-state and next-output logic; every output is the registered copy of its *_n value.
    always_comb begin
        state_n        = state;
        sel_n          = sel;
        ptr_n          = ptr;
        cnt_n          = cnt;
        gnt_a_n        = GntA;
        gnt_b_n        = GntB;
        ocupado_n      = Ocupado;
        dec_entrada_n  = Dec_Entrada;
        codigo_n       = Codigo;
        erro_n         = Erro;
        dec_controle_n = 1'b0;
        dec_reset_n    = 1'b0;
        fim_n          = 1'b0;
        close          = 1'b0;
        close_err      = 1'b0;
`ifdef SEQ_DECOD_TIMEOUT_EN
        wait_n         = '0;
`endif

        case (state)
            IDLE: begin
                if (ReqA || ReqB) begin
                    sel_n       = pick_b;
                    gnt_a_n     = ~pick_b;
                    gnt_b_n     = pick_b;
                    ocupado_n   = 1'b1;
                    dec_reset_n = 1'b1;
                    state_n     = LIMPA;
                end
            end
            LIMPA: begin
                cnt_n   = '0;
                state_n = RECV;
            end
            RECV: begin
                if (xfer) begin
                    dec_entrada_n  = sel_sym;
                    cnt_n          = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
                    dec_controle_n = 1'b1;
                    state_n        = EMITE;
                end else if (!sel_req) begin
                    close     = 1'b1;
                    close_err = 1'b1;
                end
`ifdef SEQ_DECOD_TIMEOUT_EN
                else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                    close     = 1'b1;
                    close_err = 1'b1;
                end else begin
                    wait_n = wait_cnt + WAIT_W'(1);
                end
`endif
            end
            EMITE: begin
                state_n = CHECA;
            end
            CHECA: begin
                if (Dec_Saida == SAIDA_ACC_0 || Dec_Saida == SAIDA_ACC_1) begin
                    close = 1'b1;
                end else if (Dec_Saida == SAIDA_ERRO || cnt == CNT_MAX) begin
                    close     = 1'b1;
                    close_err = 1'b1;
                end else begin
                    state_n = RECV;
                end
            end
            FIM: begin
                ptr_n   = ~sel;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Session close: Fim, Codigo and Erro become visible together with the grant release.
        if (close) begin
            state_n   = FIM;
            fim_n     = 1'b1;
            codigo_n  = Dec_Saida;
            erro_n    = close_err;
            gnt_a_n   = 1'b0;
            gnt_b_n   = 1'b0;
            ocupado_n = 1'b0;
        end

        ready_a_n = (state_n == RECV) & ~sel_n;
        ready_b_n = (state_n == RECV) & sel_n;
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state        <= IDLE;
            sel          <= 1'b0;
            ptr          <= 1'b0;
            cnt          <= '0;
            GntA         <= 1'b0;
            GntB         <= 1'b0;
            ReadyA       <= 1'b0;
            ReadyB       <= 1'b0;
            Dec_Entrada  <= '0;
            Dec_Controle <= 1'b0;
            Dec_Reset    <= 1'b1;
            Fim          <= 1'b0;
            Codigo       <= '0;
            Erro         <= 1'b0;
            Ocupado      <= 1'b0;
        end else begin
            state        <= state_n;
            sel          <= sel_n;
            ptr          <= ptr_n;
            cnt          <= cnt_n;
            GntA         <= gnt_a_n;
            GntB         <= gnt_b_n;
            ReadyA       <= ready_a_n;
            ReadyB       <= ready_b_n;
            Dec_Entrada  <= dec_entrada_n;
            Dec_Controle <= dec_controle_n;
            Dec_Reset    <= dec_reset_n;
            Fim          <= fim_n;
            Codigo       <= codigo_n;
            Erro         <= erro_n;
            Ocupado      <= ocupado_n;
        end
    end

`ifdef SEQ_DECOD_TIMEOUT_EN
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_n;
        end
    end
`endif

endmodule

// File: tb/tb_sequenciador_decod.sv
// Bench for sequenciador_decod: stand-in decoder model, session drivers and a Fim scoreboard.
// Honours SEQ_DECOD_TIMEOUT_EN for the idle-source scenario.
module tb_sequenciador_decod;

    logic       clk;
    logic       Reset;
    logic       ReqA, ReqB, ValidA, ValidB;
    logic [6:0] SimboloA, SimboloB;
    logic       ReadyA, ReadyB, GntA, GntB;
    logic [6:0] Dec_Entrada;
    logic       Dec_Controle, Dec_Reset;
    logic [3:0] Dec_Saida;
    logic       Fim;
    logic [3:0] Codigo;
    logic       Erro, Ocupado;

    sequenciador_decod #(.MAX_SIMB(8), .TIMEOUT(16)) dut (
        .clk(clk), .Reset(Reset),
        .ReqA(ReqA), .ReqB(ReqB), .ValidA(ValidA), .ValidB(ValidB),
        .SimboloA(SimboloA), .SimboloB(SimboloB),
        .ReadyA(ReadyA), .ReadyB(ReadyB), .GntA(GntA), .GntB(GntB),
        .Dec_Entrada(Dec_Entrada), .Dec_Controle(Dec_Controle), .Dec_Reset(Dec_Reset),
        .Dec_Saida(Dec_Saida), .Fim(Fim), .Codigo(Codigo), .Erro(Erro), .Ocupado(Ocupado)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in decoder: 0 -1100000-> 1 -1000100-> 2 -1100000-> 1, 1 -1001001-> 9, else 8; 8..10 absorb.
    logic [3:0] dec_st;
    function automatic logic [3:0] dec_next(input logic [3:0] st, input logic [6:0] sym);
        if (st >= 4'd8) return st;
        case (sym)
            7'b1100000: return (st == 4'd0 || st == 4'd2) ? 4'd1 : 4'd8;
            7'b1000100: return (st == 4'd1) ? 4'd2 : 4'd8;
            7'b1001001: return (st == 4'd1) ? 4'd9 : 4'd8;
            default:    return 4'd8;
        endcase
    endfunction
    always @(posedge clk) begin
        if (Dec_Reset) dec_st <= 4'd0;
        else if (Dec_Controle) dec_st <= dec_next(dec_st, Dec_Entrada);
    end
    assign Dec_Saida = dec_st;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0] codigo;
        logic       erro;
        logic       src;
    } exp_t;
    exp_t sb_q[$];
    int   ctrl_q[$];
    int   cyc = 0;
    int   fim_cnt = 0;
    logic last_src = 1'b0;

    task automatic push_exp(input logic [3:0] codigo, input logic erro, input logic src);
        exp_t e;
        e.codigo = codigo;
        e.erro   = erro;
        e.src    = src;
        sb_q.push_back(e);
    endtask

    // Scoreboard side: every Fim pops one expected session result.
    always @(posedge clk) begin
        exp_t e;
        #2;
        cyc++;
        if (Dec_Controle) ctrl_q.push_back(cyc);
        if (Fim) begin
            fim_cnt++;
            if (sb_q.size() == 0) begin
                check_eq("fim_unexpected", 32'(sb_q.size()), 1);
            end else begin
                e = sb_q.pop_front();
                check_eq("fim_codigo", 32'(Codigo), 32'(e.codigo));
                check_eq("fim_erro", 32'(Erro), 32'(e.erro));
                check_eq("fim_src", 32'(last_src), 32'(e.src));
                check_eq("fim_gnt_off", 32'({GntA, GntB}), 0);
                check_eq("fim_ocupado", 32'(Ocupado), 0);
            end
        end
        if (GntA) last_src = 1'b0;
        else if (GntB) last_src = 1'b1;
    end

    task automatic set_req(input logic src, input logic v);
        if (src) ReqB = v; else ReqA = v;
    endtask

    task automatic set_valid(input logic src, input logic v, input logic [6:0] sym);
        if (src) begin ValidB = v; SimboloB = sym; end
        else begin ValidA = v; SimboloA = sym; end
    endtask

    function automatic logic get_gnt(input logic src);
        return src ? GntB : GntA;
    endfunction

    function automatic logic get_ready(input logic src);
        return src ? ReadyB : ReadyA;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fim(input string tag);
        int k = 0;
        while (!Fim && k < 100) begin tick(); k++; end
        check_eq(tag, 32'(Fim), 1);
    endtask

    task automatic run_session(input logic src, input logic [6:0] syms [8], input int n,
                               input logic hold_req);
        int k;
        set_req(src, 1'b1);
        k = 0;
        while (!get_gnt(src) && k < 200) begin tick(); k++; end
        check_eq(src ? "grant_b_seen" : "grant_a_seen", 32'(get_gnt(src)), 1);
        for (int i = 0; i < n; i++) begin
            set_valid(src, 1'b1, syms[i]);
            k = 0;
            while (!get_ready(src) && k < 100) begin tick(); k++; end
            check_eq("ready_seen", 32'(get_ready(src)), 1);
            tick();
            set_valid(src, 1'b0, syms[i]);
        end
        wait_fim("session_fim");
        if (!hold_req) set_req(src, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] s_acc [8];
        logic [6:0] s_err [8];
        logic [6:0] s_ovf [8];
        int k;
        int fim_before;

        s_acc = '{7'b1100000, 7'b1001001, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0};
        s_err = '{7'b1100000, 7'b1111100, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0};
        for (int i = 0; i < 8; i++) s_ovf[i] = (i % 2 == 0) ? 7'b1100000 : 7'b1000100;

        Reset = 1'b1;
        ReqA = 1'b0; ReqB = 1'b0; ValidA = 1'b0; ValidB = 1'b0;
        SimboloA = 7'd0; SimboloB = 7'd0;
        #2 Reset = 1'b0;
        #1;
        check_eq("rst_gnt", 32'({GntA, GntB}), 0);
        check_eq("rst_ready", 32'({ReadyA, ReadyB}), 0);
        check_eq("rst_controle", 32'(Dec_Controle), 0);
        check_eq("rst_entrada", 32'(Dec_Entrada), 0);
        check_eq("rst_dec_reset", 32'(Dec_Reset), 1);
        check_eq("rst_fim", 32'(Fim), 0);
        check_eq("rst_codigo", 32'(Codigo), 0);
        check_eq("rst_erro", 32'(Erro), 0);
        check_eq("rst_ocupado", 32'(Ocupado), 0);
        repeat (3) @(posedge clk);
        @(negedge clk) Reset = 1'b1;
        tick();
        check_eq("idle_dec_reset", 32'(Dec_Reset), 0);

        // Round-robin: A first after reset, then B even though A keeps requesting.
        push_exp(4'd9, 1'b0, 1'b0);
        push_exp(4'd9, 1'b0, 1'b1);
        fork
            run_session(1'b0, s_acc, 2, 1'b1);
            run_session(1'b1, s_acc, 2, 1'b0);
        join
        ReqA = 1'b0;
        repeat (3) tick();

        // Basic accept with grant/ready latency and Controle spacing.
        push_exp(4'd9, 1'b0, 1'b0);
        ctrl_q.delete();
        ReqA = 1'b1;
        tick();
        check_eq("gnt_latency", 32'(GntA), 1);
        check_eq("limpa_ready", 32'(ReadyA), 0);
        check_eq("limpa_dec_reset", 32'(Dec_Reset), 1);
        check_eq("limpa_ocupado", 32'(Ocupado), 1);
        tick();
        check_eq("ready_latency", 32'({ReadyA, ReadyB}), 32'(2'b10));
        check_eq("recv_dec_reset", 32'(Dec_Reset), 0);
        run_session(1'b0, s_acc, 2, 1'b0);
        check_eq("ctrl_pulses", 32'(ctrl_q.size()), 2);
        if (ctrl_q.size() >= 2) check_eq("ctrl_spacing", 32'(ctrl_q[1] - ctrl_q[0]), 3);
        check_eq("entrada_hold", 32'(Dec_Entrada), 32'(7'b1001001));
        repeat (2) tick();

        // Decoder error; Codigo and Erro must hold afterwards.
        push_exp(4'd8, 1'b1, 1'b0);
        run_session(1'b0, s_err, 2, 1'b0);
        repeat (3) tick();
        check_eq("codigo_hold", 32'(Codigo), 8);
        check_eq("erro_hold", 32'(Erro), 1);

        // Symbol-count overflow at MAX_SIMB.
        push_exp(4'd2, 1'b1, 1'b0);
        run_session(1'b0, s_ovf, 8, 1'b0);
        repeat (2) tick();

        // Idle source: timeout (if built) or withdrawal.
        push_exp(4'd0, 1'b1, 1'b0);
        ReqA = 1'b1;
        k = 0;
        while (!ReadyA && k < 20) begin tick(); k++; end
        check_eq("idle_ready", 32'(ReadyA), 1);
`ifdef SEQ_DECOD_TIMEOUT_EN
        k = 0;
        while (!Fim && k < 40) begin tick(); k++; end
        check_eq("timeout_cycles", 32'(k), 16);
`else
        fim_before = fim_cnt;
        repeat (30) tick();
        check_eq("no_timeout", 32'(fim_cnt - fim_before), 0);
        ReqA = 1'b0;
        tick();
        check_eq("withdraw_fim", 32'(Fim), 1);
`endif
        ReqA = 1'b0;
        repeat (3) tick();

        // Reset during EMITE of a B session; afterwards A must win.
        ReqA = 1'b1;
        ReqB = 1'b1;
        set_valid(1'b1, 1'b1, 7'b1100000);
        k = 0;
        while (!GntB && k < 20) begin tick(); k++; end
        check_eq("ptr_b_grant", 32'({GntA, GntB}), 32'(2'b01));
        k = 0;
        while (!Dec_Controle && k < 20) begin tick(); k++; end
        check_eq("emite_reached", 32'(Dec_Controle), 1);
        fim_before = fim_cnt;
        Reset = 1'b0;
        #1;
        check_eq("mid_dec_reset", 32'(Dec_Reset), 1);
        check_eq("mid_gnt", 32'({GntA, GntB}), 0);
        check_eq("mid_fim", 32'(Fim), 0);
        check_eq("mid_ocupado", 32'(Ocupado), 0);
        check_eq("mid_ready", 32'({ReadyA, ReadyB}), 0);
        check_eq("mid_controle", 32'(Dec_Controle), 0);
        check_eq("mid_entrada", 32'(Dec_Entrada), 0);
        set_valid(1'b1, 1'b0, 7'd0);
        @(negedge clk) Reset = 1'b1;
        tick();
        check_eq("post_reset_grant", 32'({GntA, GntB}), 32'(2'b10));
        check_eq("mid_no_fim", 32'(fim_cnt - fim_before), 0);
        push_exp(4'd0, 1'b1, 1'b0);
        ReqA = 1'b0;
        ReqB = 1'b0;
        wait_fim("post_reset_fim");
        repeat (3) tick();

        check_eq("sb_drained", 32'(sb_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
